// File: rtl/i2c_slave_pkg.sv
// Shared types and bus-level constants for the I2C target responder.
package i2c_slave_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_slv_state_e;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Pad and register-write notification signals of the I2C target responder.
interface i2c_slave_responder_if #(
    parameter int unsigned PTR_W = 4
);
    logic             scl_i;
    logic             sda_i;
    logic             sda_oe;
    logic             busy;
    logic             addr_hit;
    logic             wr_strobe;
    logic [PTR_W-1:0] wr_index;
    logic [7:0]       wr_data;

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_oe,
        output busy,
        output addr_hit,
        output wr_strobe,
        output wr_index,
        output wr_data
    );

    modport master (
        output scl_i,
        output sda_i,
        input  sda_oe,
        input  busy,
        input  addr_hit,
        input  wr_strobe,
        input  wr_index,
        input  wr_data
    );
endinterface

// File: rtl/i2c_bus_cond.sv
// Synchronises the SCL/SDA pads and flags SCL edges plus START/STOP conditions.
module i2c_bus_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic       scl_s;

    // Two-stage synchronisers plus one history stage; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, pointer/data writes and sequential reads of a byte array.
module i2c_slave_responder
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR = 7'h50,
    parameter int unsigned DEPTH    = 16
) (
    input logic clk,
    input logic rst_n,
    i2c_slave_responder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic scl_rise;
    logic scl_fall;
    logic sda_s;
    logic start_det;
    logic stop_det;

    i2c_bus_cond u_cond (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_slv_state_e         state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0]      shreg;
    logic [PTR_W-1:0]       ptr;
    logic                   ack_seen;
    logic [BYTE_W-1:0]      mem [DEPTH];

    logic                   sda_oe_q;
    logic                   busy_q;
    logic                   addr_hit_q;
    logic                   wr_strobe_q;
    logic [PTR_W-1:0]       wr_index_q;
    logic [BYTE_W-1:0]      wr_data_q;

    logic [BYTE_W-1:0]      byte_in;
    logic [PTR_W-1:0]       ptr_inc;
    logic [BYTE_W-1:0]      cur_byte;
    logic [BYTE_W-1:0]      nxt_byte;

    assign byte_in  = {shreg[BYTE_W-2:0], sda_s};
    assign ptr_inc  = ptr + PTR_W'(1);
    assign cur_byte = mem[ptr];
    assign nxt_byte = mem[ptr_inc];

    // Protocol FSM; bus conditions override bit handling. In slave-ACK states
    // sda_oe itself marks whether the ACK bit has started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            ptr         <= '0;
            ack_seen    <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            addr_hit_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            addr_hit_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            if (stop_det) begin
                state    <= IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
                ack_seen <= 1'b0;
            end else if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= BIT_CNT_W'(7);
                busy_q   <= 1'b1;
                sda_oe_q <= 1'b0;
                ack_seen <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg <= byte_in;
                            if (bit_cnt == '0) begin
                                if (byte_in[7:1] == SLV_ADDR) begin
                                    state      <= ADDR_ACK;
                                    addr_hit_q <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else if (shreg[0] == I2C_RW_READ) begin
                                shreg    <= cur_byte;
                                sda_oe_q <= ~cur_byte[7];
                                bit_cnt  <= BIT_CNT_W'(7);
                                state    <= RD_DATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                bit_cnt  <= BIT_CNT_W'(7);
                                state    <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shreg <= byte_in;
                            if (bit_cnt == '0) begin
                                ptr   <= byte_in[PTR_W-1:0];
                                state <= PTR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                            end
                        end
                    end
                    PTR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                bit_cnt  <= BIT_CNT_W'(7);
                                state    <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg <= byte_in;
                            if (bit_cnt == '0) begin
                                mem[ptr]    <= byte_in;
                                wr_strobe_q <= 1'b1;
                                wr_index_q  <= ptr;
                                wr_data_q   <= byte_in;
                                ptr         <= ptr_inc;
                                state       <= WR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                            end
                        end
                    end
                    RD_DATA: begin
                        // Bit 7 is already on the bus; each fall presents the next bit.
                        if (scl_fall) begin
                            if (bit_cnt == '0) begin
                                sda_oe_q <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                sda_oe_q <= ~shreg[6];
                                shreg    <= {shreg[6:0], 1'b0};
                                bit_cnt  <= bit_cnt - BIT_CNT_W'(1);
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                ack_seen <= 1'b1;
                                ptr      <= ptr_inc;
                                shreg    <= nxt_byte;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && ack_seen) begin
                            ack_seen <= 1'b0;
                            sda_oe_q <= ~shreg[7];
                            bit_cnt  <= BIT_CNT_W'(7);
                            state    <= RD_DATA;
                        end
                    end
                    IGNORE: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.busy      = busy_q;
    assign bus.addr_hit  = addr_hit_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_index  = wr_index_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master against the responder with hand-computed expectations.
module tb_i2c_slave_responder;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic m_scl;
    logic m_sda;

    always #5 clk = ~clk;

    i2c_slave_responder_if #(.PTR_W(4)) bus ();

    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    i2c_slave_responder #(.SLV_ADDR(7'h50), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hit_cnt  = 0;
    logic [3:0] s_idx [$];
    logic [7:0] s_dat [$];

    always @(negedge clk) begin
        if (bus.addr_hit) hit_cnt++;
        if (bus.wr_strobe) begin
            s_idx.push_back(bus.wr_index);
            s_dat.push_back(bus.wr_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        m_sda = 1'b1; wclk(Q);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;    wclk(Q);
        m_scl = 1'b1; wclk(2 * Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        b = bus.sda_i; wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(ack_bit);
    endtask

    task automatic check_strobe(input string tag, input int k, input logic [3:0] idx, input logic [7:0] dat);
        logic [3:0] gi;
        logic [7:0] gd;
        gi = (k < s_idx.size()) ? s_idx[k] : 4'bx;
        gd = (k < s_dat.size()) ? s_dat[k] : 8'bx;
        check_eq({tag, " idx"}, 32'(gi), 32'(idx));
        check_eq({tag, " data"}, 32'(gd), 32'(dat));
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         base;
        int         h0;

        m_scl = 1'b1;
        m_sda = 1'b1;
        rst_n = 1'b0;
        wclk(3);
        check_eq("rst sda_oe", 32'(bus.sda_oe), 0);
        check_eq("rst busy", 32'(bus.busy), 0);
        check_eq("rst addr_hit", 32'(bus.addr_hit), 0);
        check_eq("rst wr_strobe", 32'(bus.wr_strobe), 0);
        check_eq("rst wr_index", 32'(bus.wr_index), 0);
        check_eq("rst wr_data", 32'(bus.wr_data), 0);
        rst_n = 1'b1;
        wclk(5);

        // Write ptr 3, data 0x11 0x22
        base = s_idx.size(); h0 = hit_cnt;
        i2c_start();
        put_byte(8'hA0, ack); check_eq("t1 addr ack", 32'(ack), 0);
        check_eq("t1 busy", 32'(bus.busy), 1);
        put_byte(8'h03, ack); check_eq("t1 ptr ack", 32'(ack), 0);
        put_byte(8'h11, ack); check_eq("t1 d0 ack", 32'(ack), 0);
        put_byte(8'h22, ack); check_eq("t1 d1 ack", 32'(ack), 0);
        i2c_stop(); wclk(5);
        check_eq("t1 busy after stop", 32'(bus.busy), 0);
        check_eq("t1 addr_hit count", 32'(hit_cnt - h0), 1);
        check_eq("t1 strobe count", 32'(s_idx.size() - base), 2);
        check_strobe("t1 s0", base, 4'd3, 8'h11);
        check_strobe("t1 s1", base + 1, 4'd4, 8'h22);

        // Pointer set then repeated START read of three bytes
        base = s_idx.size();
        i2c_start();
        put_byte(8'hA0, ack); check_eq("t2 addr ack", 32'(ack), 0);
        put_byte(8'h03, ack); check_eq("t2 ptr ack", 32'(ack), 0);
        i2c_rstart();
        put_byte(8'hA1, ack); check_eq("t2 rd addr ack", 32'(ack), 0);
        get_byte(d, 1'b0); check_eq("t2 rd0", 32'(d), 32'h11);
        get_byte(d, 1'b0); check_eq("t2 rd1", 32'(d), 32'h22);
        get_byte(d, 1'b1); check_eq("t2 rd2", 32'(d), 32'h00);
        check_eq("t2 sda released after nack", 32'(bus.sda_oe), 0);
        i2c_stop(); wclk(5);
        check_eq("t2 busy", 32'(bus.busy), 0);
        check_eq("t2 no strobes", 32'(s_idx.size() - base), 0);

        // Foreign address 0x51
        base = s_idx.size(); h0 = hit_cnt;
        i2c_start();
        put_byte(8'hA2, ack); check_eq("t3 addr nack", 32'(ack), 1);
        check_eq("t3 busy", 32'(bus.busy), 1);
        put_byte(8'h55, ack); check_eq("t3 data nack", 32'(ack), 1);
        i2c_stop(); wclk(5);
        check_eq("t3 busy after stop", 32'(bus.busy), 0);
        check_eq("t3 no addr_hit", 32'(hit_cnt - h0), 0);
        check_eq("t3 no strobes", 32'(s_idx.size() - base), 0);

        // Pointer wrap on write and read
        base = s_idx.size();
        i2c_start();
        put_byte(8'hA0, ack); check_eq("t4 addr ack", 32'(ack), 0);
        put_byte(8'h0F, ack); check_eq("t4 ptr ack", 32'(ack), 0);
        put_byte(8'h5A, ack); check_eq("t4 d0 ack", 32'(ack), 0);
        put_byte(8'h6B, ack); check_eq("t4 d1 ack", 32'(ack), 0);
        i2c_stop(); wclk(5);
        check_eq("t4 strobe count", 32'(s_idx.size() - base), 2);
        check_strobe("t4 s0", base, 4'd15, 8'h5A);
        check_strobe("t4 s1", base + 1, 4'd0, 8'h6B);
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h0F, ack);
        i2c_rstart();
        put_byte(8'hA1, ack); check_eq("t4 rd addr ack", 32'(ack), 0);
        get_byte(d, 1'b0); check_eq("t4 rd15", 32'(d), 32'h5A);
        get_byte(d, 1'b1); check_eq("t4 rd0 wrap", 32'(d), 32'h6B);
        i2c_stop(); wclk(5);

        // STOP after 4 data bits discards the partial byte
        base = s_idx.size();
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h02, ack); check_eq("t6 ptr ack", 32'(ack), 0);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        i2c_stop(); wclk(5);
        check_eq("t6 busy", 32'(bus.busy), 0);
        check_eq("t6 no strobe", 32'(s_idx.size() - base), 0);
        i2c_start();
        put_byte(8'hA0, ack); check_eq("t6 next addr ack", 32'(ack), 0);
        put_byte(8'h02, ack);
        put_byte(8'h33, ack); check_eq("t6 next data ack", 32'(ack), 0);
        i2c_stop(); wclk(5);
        check_eq("t6 next strobe count", 32'(s_idx.size() - base), 1);
        check_strobe("t6 s0", base, 4'd2, 8'h33);

        // Reset while driving bit 7 (0) of mem[3]=0x11
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h03, ack);
        i2c_rstart();
        put_byte(8'hA1, ack); check_eq("t5 rd addr ack", 32'(ack), 0);
        check_eq("t5 sda_oe driving", 32'(bus.sda_oe), 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5 sda_oe async release", 32'(bus.sda_oe), 0);
        check_eq("t5 busy in reset", 32'(bus.busy), 0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wclk(3);
        rst_n = 1'b1;
        wclk(5);
        base = s_idx.size();
        i2c_start();
        put_byte(8'hA0, ack); check_eq("t5 wr addr ack", 32'(ack), 0);
        put_byte(8'h00, ack);
        put_byte(8'h77, ack); check_eq("t5 wr data ack", 32'(ack), 0);
        i2c_stop(); wclk(5);
        check_strobe("t5 s0", base, 4'd0, 8'h77);
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h03, ack);
        i2c_rstart();
        put_byte(8'hA1, ack);
        get_byte(d, 1'b1); check_eq("t5 mem3 cleared", 32'(d), 32'h00);
        i2c_stop(); wclk(5);
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h00, ack);
        i2c_rstart();
        put_byte(8'hA1, ack);
        get_byte(d, 1'b0); check_eq("t5 rd0", 32'(d), 32'h77);
        get_byte(d, 1'b1); check_eq("t5 rd1 cleared", 32'(d), 32'h00);
        i2c_stop(); wclk(5);
        check_eq("t5 busy end", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) that answers transactions from the I2C master agent on the shared open-drain `scl`/`sda` bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs, and serves an internal byte-register array:
  - write: pointer byte, then data bytes;
  - read: data from the current pointer.
- Drives SDA low only (open-drain). The testbench top resolves `sda = sda_oe ? 0 : z`, with weak pull-up.

Parameters:
- SLV_ADDR, 7'h50, 7-bit target address.
- DEPTH, 16, register array entries (power of two, 2..256).
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  system clock; must be ≥ 10× SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  SCL pad value (asynchronous).
- sda_i  input  1  SDA pad value (asynchronous, resolved bus).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- busy  output  1  high from START to STOP/abort.
- addr_hit  output  1  one-clk pulse when address byte matches.
- wr_strobe  output  1  one-clk pulse per stored data byte.
- wr_index  output  PTR_W  index written on wr_strobe.
- wr_data  output  8  byte written on wr_strobe.

Behaviour:
- Reset (async, rst_n=0):
  - sda_oe=0, busy=0, addr_hit=0, wr_strobe=0, wr_index=0, wr_data=0.
  - ptr=0, all array bytes=8'h00, state=IDLE.
  - Synchronizer flops reset to 1.
- Reset asserted mid-transfer releases SDA immediately (combinationally through the flops).
- Input conditioning:
  - 2-flop synchronizer per line, plus one history flop.
  - scl_rise/scl_fall = edge of synced SCL.
  - START = synced SDA 1→0 while synced SCL=1.
  - STOP = synced SDA 0→1 while synced SCL=1.
- Sample/drive timing:
  - SDA is sampled on the clk where scl_rise is seen.
  - sda_oe changes only on the clk after scl_fall is seen. Latency from pad SCL fall to sda_oe change is 3 clk.
- Bits are MSB first; bit counter runs 7→0.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - IDLE: START → ADDR, busy=1.
  - ADDR: shift 8 bits.
    - addr[7:1]==SLV_ADDR → ADDR_ACK, addr_hit pulse.
    - Otherwise → IGNORE (no ACK).
  - ADDR_ACK: sda_oe=1 for the ACK bit.
    - R/W=0 → PTR.
    - R/W=1 → RD_DATA, load shift reg with mem[ptr].
  - PTR: 8 bits; ptr = byte[PTR_W-1:0] (upper bits dropped). → PTR_ACK (ACK) → WR_DATA.
  - WR_DATA: 8 bits, then:
    - mem[ptr] = byte;
    - wr_strobe pulse with wr_index=ptr, wr_data=byte;
    - ptr = ptr+1 mod DEPTH;
    - → WR_ACK (ACK) → WR_DATA.
  - RD_DATA: drive sda_oe = ~bit on each scl_fall; release after bit 0. → RD_ACK.
  - RD_ACK: sample master bit at scl_rise.
    - 0 (ACK): ptr++ mod DEPTH; load mem[ptr]; → RD_DATA.
    - 1 (NACK): → IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- STOP in any state → IDLE, busy=0, sda_oe=0.
- START in any non-IDLE state (repeated START) → ADDR, bit counter reset; ptr retained.
- A partially received byte is discarded on START/STOP; no write occurs.
- ptr wraps DEPTH-1 → 0 on both read and write.
- Simultaneous START and scl edge cannot occur, since START requires SCL high. START/STOP take priority over bit handling in the same clk.

Decomposition:
- Package i2c_slave_pkg:
  - state enum i2c_slv_state_e;
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_RW_READ=1'b1.
- Sub-module i2c_bus_cond:
  - synchronizers and history flops;
  - outputs scl_rise, scl_fall, sda_s, start_det, stop_det.
- Top holds the FSM, shift register, bit counter, ptr and register array.

Test Plan:
- Write 0xA0, ptr 0x03, data 0x11, 0x22, STOP → addr_hit once; all ACKs low; wr_strobe×2 (idx3=0x11, idx4=0x22); busy 0 after STOP.
- Write ptr 0x03, repeated START, read 0xA1 three bytes (ACK, ACK, NACK), STOP → returns 0x11, 0x22, 0x00; SDA released after the NACK.
- Address 0xA2 (0x51 write) → no ACK (SDA high at 9th clock); no strobes; busy drops at STOP.
- Write ptr 0x0F, data 0x5A, 0x6B → wr_index 15 then 0 (wrap); read-back from ptr 0x0F yields 0x5A, 0x6B.
- rst_n low mid-RD_DATA while sda_oe=1 → sda_oe 0 in same cycle; after release, new write at ptr 0 works and mem holds 0x00 elsewhere.
- STOP after 4 bits of a write data byte → no wr_strobe; state IDLE; next transaction normal.
